// File: rtl/int2float_pipe.sv
// Two-stage pipelined integer to minifloat encoder with valid/ready streaming.
// S1 takes magnitude and leading-one index; S2 normalises, rounds, saturates.
module int2float_pipe #(
    parameter int unsigned IN_W   = 11,
    parameter int unsigned MANT_W = 4,
    parameter int unsigned EXP_W  = 3,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned ROUND  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_ovf
);
    localparam int unsigned P_W  = $clog2(IN_W);
    localparam int unsigned XE_W = EXP_W + 1;
    localparam logic [XE_W-1:0] EXP_MAX = XE_W'((1 << EXP_W) - 1);

    if (IN_W < MANT_W + 1 || IN_W > 64 || IN_W - MANT_W > (1 << EXP_W) - 1) begin : g_bad_params
        $error("int2float_pipe: illegal IN_W/MANT_W/EXP_W combination");
    end

    logic            en;
    logic            s1_valid, s1_sign, s1_zero;
    logic [IN_W-1:0] s1_mag;
    logic [P_W-1:0]  s1_msb;

    logic            neg_c;
    logic [IN_W-1:0] mag_c;
    logic [P_W-1:0]  msb_c;

    // Global stall: every stage advances only when the output slot frees up.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    always_comb begin
        neg_c = (SIGNED != 0) && in_data[IN_W-1];
        mag_c = neg_c ? (~in_data + IN_W'(1)) : in_data;
        msb_c = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (mag_c[i]) msb_c = P_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_mag   <= '0;
            s1_msb   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= neg_c;
                s1_zero <= (mag_c == '0);
                s1_mag  <= mag_c;
                s1_msb  <= msb_c;
            end
        end
    end

    logic [P_W-1:0]    shift_c;
    logic [IN_W-1:0]   rem_c, half_c;
    logic [MANT_W-1:0] mant_c;
    logic [XE_W-1:0]   exp_c;
    logic              up_c, ovf_c;

    // Normalise, round to nearest even and saturate on exponent overflow.
    always_comb begin
        shift_c = '0;
        rem_c   = '0;
        half_c  = '0;
        up_c    = 1'b0;
        mant_c  = '0;
        exp_c   = '0;
        ovf_c   = 1'b0;
        if (s1_msb < P_W'(MANT_W)) begin
            mant_c = s1_mag[MANT_W-1:0];
        end else begin
            shift_c = s1_msb - P_W'(MANT_W);
            mant_c  = MANT_W'(s1_mag >> shift_c);
            rem_c   = s1_mag & ((IN_W'(1) << shift_c) - IN_W'(1));
            exp_c   = XE_W'(shift_c) + XE_W'(1);
            if (shift_c != '0) begin
                half_c = IN_W'(1) << (shift_c - P_W'(1));
            end
            if (ROUND != 0 && shift_c != '0) begin
                up_c = (rem_c > half_c) || (rem_c == half_c && mant_c[0]);
            end
            if (up_c) begin
                mant_c = mant_c + MANT_W'(1);
                if (mant_c == '0) exp_c = exp_c + XE_W'(1);
            end
            if (exp_c > EXP_MAX) begin
                exp_c  = EXP_MAX;
                mant_c = '1;
                ovf_c  = 1'b1;
            end
        end
    end

    // Output registers; an empty slot loads zeros so stale data never leaks.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_sign  <= s1_valid & s1_sign;
            out_exp   <= s1_valid ? exp_c[EXP_W-1:0] : '0;
            out_mant  <= s1_valid ? mant_c : '0;
            out_zero  <= s1_valid & s1_zero;
            out_ovf   <= s1_valid & ovf_c;
        end
    end
endmodule

// File: tb/tb_int2float_pipe.sv
// Bench for int2float_pipe: four parameter sets share one stimulus stream,
// each checked by a scoreboard fed from an arithmetic reference encoder.
module tb_int2float_pipe;
    typedef struct packed {
        logic       s;
        logic [7:0] e;
        logic [7:0] m;
        logic       z;
        logic       o;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] din = 16'd0;

    logic rdy [4];
    logic ov  [4];
    res_t obs [4];

    logic       s0, s1, s2, s3, z0, z1, z2, z3, o0, o1, o2, o3;
    logic [2:0] e0, e1, e2;
    logic [3:0] m0, m1, m2, e3;
    logic [4:0] m3;

    int   n_assert = 0;
    int   n_fail   = 0;
    res_t q [4][$];
    bit   stl [4];
    res_t prev [4];
    res_t lit [3][9];
    logic [15:0] vec [9];
    int   sent;
    bit   bv, bo, acc;
    logic [15:0] bd;

    always #5 clk = ~clk;

    int2float_pipe #(.IN_W(11), .MANT_W(4), .EXP_W(3), .SIGNED(0), .ROUND(0)) d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(din[10:0]),
        .out_valid(ov[0]), .out_ready(out_ready), .out_sign(s0), .out_exp(e0), .out_mant(m0),
        .out_zero(z0), .out_ovf(o0));
    int2float_pipe #(.IN_W(11), .MANT_W(4), .EXP_W(3), .SIGNED(0), .ROUND(1)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(din[10:0]),
        .out_valid(ov[1]), .out_ready(out_ready), .out_sign(s1), .out_exp(e1), .out_mant(m1),
        .out_zero(z1), .out_ovf(o1));
    int2float_pipe #(.IN_W(11), .MANT_W(4), .EXP_W(3), .SIGNED(1), .ROUND(0)) d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(din[10:0]),
        .out_valid(ov[2]), .out_ready(out_ready), .out_sign(s2), .out_exp(e2), .out_mant(m2),
        .out_zero(z2), .out_ovf(o2));
    int2float_pipe #(.IN_W(16), .MANT_W(5), .EXP_W(4), .SIGNED(0), .ROUND(1)) d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(din),
        .out_valid(ov[3]), .out_ready(out_ready), .out_sign(s3), .out_exp(e3), .out_mant(m3),
        .out_zero(z3), .out_ovf(o3));

    assign obs[0] = {s0, 8'(e0), 8'(m0), z0, o0};
    assign obs[1] = {s1, 8'(e1), 8'(m1), z1, o1};
    assign obs[2] = {s2, 8'(e2), 8'(m2), z2, o2};
    assign obs[3] = {s3, 8'(e3), 8'(m3), z3, o3};

    function automatic res_t mk(input bit s, input int e, input int m, input bit z, input bit o);
        mk = {s, 8'(e), 8'(m), z, o};
    endfunction

    // Value-level encoder: scale the magnitude down, round the quotient, renormalise.
    function automatic res_t model(input logic [15:0] dv, input int iw, input int mw,
                                   input int ew, input bit sgn, input bit rnd);
        res_t r;
        longint unsigned raw, b, scale, qt, rem;
        int p, e;
        r   = '0;
        raw = 64'(dv) & ((64'd1 << iw) - 64'd1);
        b   = raw;
        if (sgn && raw >= (64'd1 << (iw - 1))) begin
            r.s = 1'b1;
            b   = (64'd1 << iw) - raw;
        end
        if (b == 64'd0) begin
            r.z = 1'b1;
            return r;
        end
        if (b < (64'd1 << mw)) begin
            r.m = 8'(b);
            return r;
        end
        p = 0;
        while ((b >> (p + 1)) != 64'd0) p++;
        scale = 64'd1 << (p - mw);
        qt    = b / scale;
        rem   = b % scale;
        e     = p - mw + 1;
        if (rnd && (64'd2 * rem > scale || (64'd2 * rem == scale && qt[0]))) qt++;
        if (qt == (64'd2 << mw)) begin
            qt = qt / 64'd2;
            e++;
        end
        if (e > (1 << ew) - 1) begin
            r.e = 8'((1 << ew) - 1);
            r.m = 8'((1 << mw) - 1);
            r.o = 1'b1;
            return r;
        end
        r.e = 8'(e);
        r.m = 8'(qt - (64'd1 << mw));
        return r;
    endfunction

    function automatic res_t model_k(input int k, input logic [15:0] dv);
        case (k)
            0:       model_k = model(dv, 11, 4, 3, 1'b0, 1'b0);
            1:       model_k = model(dv, 11, 4, 3, 1'b0, 1'b1);
            2:       model_k = model(dv, 11, 4, 3, 1'b1, 1'b0);
            default: model_k = model(dv, 16, 5, 4, 1'b0, 1'b1);
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] o, input logic [31:0] x);
        n_assert++;
        assert (o === x) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, o, x);
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_valid"}, k, 32'(ov[k]), 32'd0);
            chk({tag, "_data"}, k, 32'(obs[k]), 32'd0);
            chk({tag, "_ready"}, k, 32'(rdy[k]), 32'd1);
        end
    endtask

    // One clock: drive, sample at negedge, score the handshakes of the coming edge.
    task automatic step(input bit v, input logic [15:0] d, input bit ordy, input bit r);
        res_t ex;
        in_valid  = v;
        din       = d;
        out_ready = ordy;
        rst       = r;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (stl[k]) begin
                chk("hold_valid", k, 32'(ov[k]), 32'd1);
                chk("hold_data", k, 32'(obs[k]), 32'(prev[k]));
            end
            chk("in_ready", k, 32'(rdy[k]), 32'(!ov[k] || ordy));
            if (r) begin
                q[k].delete();
                stl[k] = 1'b0;
            end else begin
                if (ov[k] && ordy) begin
                    if (q[k].size() == 0) begin
                        chk("extra_word", k, 32'(ov[k]), 32'd0);
                    end else begin
                        ex = q[k].pop_front();
                        chk("data", k, 32'(obs[k]), 32'(ex));
                    end
                end
                if (v && rdy[k]) q[k].push_back(model_k(k, d));
                stl[k]  = ov[k] && !ordy;
                prev[k] = obs[k];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 8; c++) step(1'b0, 16'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) chk(tag, k, 32'(q[k].size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec = '{16'd0, 16'd15, 16'd23, 16'd1000, 16'd2047, 16'd35, 16'd63, 16'h7E9, 16'h400};
        lit[0] = '{mk(0,0,0,1,0), mk(0,0,15,0,0), mk(0,1,7,0,0), mk(0,6,15,0,0), mk(0,7,15,0,0),
                   mk(0,2,1,0,0), mk(0,2,15,0,0), mk(0,7,15,0,0), mk(0,7,0,0,0)};
        lit[1] = '{mk(0,0,0,1,0), mk(0,0,15,0,0), mk(0,1,7,0,0), mk(0,6,15,0,0), mk(0,7,15,0,1),
                   mk(0,2,2,0,0), mk(0,3,0,0,0), mk(0,7,15,0,1), mk(0,7,0,0,0)};
        lit[2] = '{mk(0,0,0,1,0), mk(0,0,15,0,0), mk(0,1,7,0,0), mk(0,6,15,0,0), mk(1,0,1,0,0),
                   mk(0,2,1,0,0), mk(0,2,15,0,0), mk(1,1,7,0,0), mk(1,7,0,0,0)};

        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");

        // Back-to-back directed words, exact 2-cycle latency, one result per cycle.
        for (int c = 0; c < 11; c++) begin
            if (c < 9) step(1'b1, vec[c], 1'b1, 1'b0);
            else       step(1'b0, 16'd0, 1'b1, 1'b0);
            for (int k = 0; k < 3; k++) begin
                if (c == 0) begin
                    chk("lat_early", k, 32'(ov[k]), 32'd0);
                end else if (c <= 9) begin
                    chk("lat_valid", k, 32'(ov[k]), 32'd1);
                    chk("vec", k, 32'(obs[k]), 32'(lit[k][c-1]));
                end
            end
        end

        // Five words under random backpressure with a forced 3-cycle stall.
        sent = 0;
        for (int c = 0; c < 80 && (sent < 5 || q[0].size() != 0 || ov[0]); c++) begin
            bo  = (c >= 2 && c <= 4) ? 1'b0 : ($urandom_range(0, 1) == 1);
            bv  = (sent < 5);
            bd  = 16'($urandom);
            acc = bv && (!ov[0] || bo);
            step(bv, bd, bo, 1'b0);
            if (acc) sent++;
        end
        chk("bp_sent", 0, 32'(sent), 32'd5);
        drain("bp_drain");

        // Random valid/ready traffic.
        for (int c = 0; c < 300; c++) begin
            step($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 3) != 0, 1'b0);
        end
        drain("rand_drain");

        // Reset while two words are in flight; nothing stale may emerge.
        step(1'b1, 16'd23, 1'b1, 1'b0);
        step(1'b1, 16'd1000, 1'b1, 1'b1);
        chk_reset("rst_mid");
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 16'd0, 1'b1, 1'b0);
            for (int k = 0; k < 4; k++) chk("no_stale", k, 32'(ov[k]), 32'd0);
        end
        step(1'b1, 16'd35, 1'b1, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("post_rst_valid", k, 32'(ov[k]), 32'd1);
            chk("post_rst_data", k, 32'(obs[k]), 32'(model_k(k, 16'd35)));
        end
        drain("rst_drain");

        // Exhaustive 16-bit sweep (the 11-bit units see the low bits).
        for (int i = 0; i < 65536; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
        drain("sweep_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
